// File: rtl/ov5640_dvp_tx.sv
// ov5640_dvp_tx
// Stands in for an OV5640 sensor on the DVP bus. It produces VSYNC, HREF and
// RGB565 bytes (high byte first) from one pixel clock. The pixel data comes
// from one of four built-in test patterns.
//
// Ports:
//   clk          pixel clock (PCLK); every output changes on its rising edge
//   rst_n        asynchronous active-low reset
//   en           run request, sampled in IDLE and on the last clock of a frame
//   pattern_sel  0 bars, 1 grey ramp, 2 frame-count colour, 3 checker
//   cmos_vsync   high for the sync period at the start of each frame
//   cmos_href    high while line bytes are valid
//   cmos_data    RGB565 byte, zero while cmos_href is low
//   frame_done   one-cycle pulse on the last clock of the front porch
//   frame_cnt    completed frames, wrapping
//   busy         high whenever a frame is in progress
module ov5640_dvp_tx #(
  parameter int H_ACTIVE = 480,
  parameter int H_BLANK  = 64,
  parameter int V_ACTIVE = 272,
  parameter int VS_LINES = 2,
  parameter int V_BACK   = 8,
  parameter int V_FRONT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int BW       = $clog2(BAR_W + 1);

  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT2 = HW'(2 * H_ACTIVE);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t       state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [15:0]  line_cnt_q, line_cnt_d;
  logic [1:0]   sel_q, sel_d;
  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]   bar_idx_q, bar_idx_d;
  logic         vsync_q, vsync_d;
  logic         href_q, href_d;
  logic [7:0]   data_q, data_d;
  logic         done_q, done_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic         busy_q, busy_d;

  logic [15:0]  last_line;
  logic [5:0]   x_hi;
  logic [15:0]  pix;

  // The outputs are computed from the next state and next counters. The
  // registered outputs then stay aligned with the state they describe, and
  // no input reaches an output without passing through a flop.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    line_cnt_d  = line_cnt_q;
    sel_d       = sel_q;
    bar_px_d    = bar_px_q;
    bar_idx_d   = bar_idx_q;
    frame_cnt_d = frame_cnt_q;
    pix         = 16'h0000;

    case (state_q)
      S_VSYNC:  last_line = 16'(VS_LINES - 1);
      S_VBACK:  last_line = 16'(V_BACK - 1);
      S_ACTIVE: last_line = 16'(V_ACTIVE - 1);
      S_VFRONT: last_line = 16'(V_FRONT - 1);
      default:  last_line = 16'h0000;
    endcase

    if (state_q == S_IDLE) begin
      if (en) begin
        state_d    = S_VSYNC;
        h_cnt_d    = '0;
        line_cnt_d = '0;
      end
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (line_cnt_q == last_line) begin
        line_cnt_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          default:  state_d = en ? S_VSYNC : S_IDLE;
        endcase
      end else begin
        line_cnt_d = line_cnt_q + 16'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end

    // The pattern is frozen for the whole frame from the moment VSYNC begins.
    if (state_d == S_VSYNC && state_q != S_VSYNC) begin
      sel_d = pattern_sel;
    end

    // The bar counter follows the pixel about to be sent. It advances on each
    // high byte, so the bar index never needs a divide by the bar width.
    if (h_cnt_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (!h_cnt_d[0]) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + BW'(1);
      end
    end

    // x_hi holds x[7:2], where x is the pixel column (h_cnt / 2).
    x_hi = 6'(h_cnt_d >> 3);

    case (sel_q)
      2'd0: begin
        case (bar_idx_d)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {x_hi[5:1], x_hi, x_hi[5:1]};
      2'd2:    pix = {frame_cnt_q[4:0], 6'b000000, ~frame_cnt_q[4:0]};
      default: pix = (x_hi[2] ^ line_cnt_d[4]) ? 16'hFFFF : 16'h0000;
    endcase

    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE) && (h_cnt_d < H_ACT2);
    data_d  = href_d ? (h_cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    done_d  = (state_d == S_VFRONT) && (line_cnt_d == 16'(V_FRONT - 1)) &&
              (h_cnt_d == H_LAST);
    if (done_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    busy_d = (state_d != S_IDLE);
  end

  // All state and outputs live in one register bank. Reset drops back to IDLE
  // and does not remember any partly sent frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      h_cnt_q     <= '0;
      line_cnt_q  <= '0;
      sel_q       <= 2'd0;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      line_cnt_q  <= line_cnt_d;
      sel_q       <= sel_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign cmos_vsync = vsync_q;
  assign cmos_href  = href_q;
  assign cmos_data  = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Testbench for ov5640_dvp_tx. It uses a reduced geometry so that several
// whole frames fit in a short run. The active line is still wider than 256
// pixels, so the grey ramp wraps within a line.
module tb_ov5640_dvp_tx;

  localparam int H_ACT    = 272;
  localparam int H_BLK    = 16;
  localparam int V_ACT    = 18;
  localparam int VS_L     = 2;
  localparam int V_BK     = 2;
  localparam int V_FR     = 2;
  localparam int LINE     = 2 * H_ACT + H_BLK;
  localparam int FRAME    = (VS_L + V_BK + V_ACT + V_FR) * LINE;
  localparam int LIMIT    = 2 * FRAME;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern_sel;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Measurements gathered by run_frame for the test tasks to judge.
  int   m_vs_len, m_back, m_lines, m_bad_len, m_bad_gap, m_tail;
  int   m_idle_data, m_timeout;
  logic [15:0] m_done_cnt;
  logic m_after_done, m_after_vs, m_after_busy;
  logic [7:0] fbuf [0:V_ACT-1][0:2*H_ACT-1];

  ov5640_dvp_tx #(
    .H_ACTIVE(H_ACT), .H_BLANK(H_BLK), .V_ACTIVE(V_ACT),
    .VS_LINES(VS_L), .V_BACK(V_BK), .V_FRONT(V_FR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame. It starts on the first cycle that shows VSYNC high and
  // ends on the cycle after frame_done. HREF pulses are counted by the bench
  // itself, and each byte is stored by line and position. When pulse act_line
  // begins, act_sel and act_en are applied.
  task automatic run_frame(input int act_line, input logic [1:0] act_sel,
                           input logic act_en);
    int cyc = 0;
    int pos = 0;
    int low = 0;
    logic prev = 1'b0;
    for (int l = 0; l < V_ACT; l++)
      for (int b = 0; b < 2*H_ACT; b++) fbuf[l][b] = 8'hxx;
    m_vs_len = 0; m_back = 0; m_lines = 0; m_bad_len = 0; m_bad_gap = 0;
    m_tail = 0; m_idle_data = 0; m_timeout = 0;
    while (cmos_vsync === 1'b1 && cyc < LIMIT) begin
      m_vs_len++; step(); cyc++;
    end
    while (cmos_href !== 1'b1 && cyc < LIMIT) begin
      m_back++; step(); cyc++;
    end
    while (frame_done !== 1'b1 && cyc < LIMIT) begin
      if (cmos_href === 1'b1) begin
        if (!prev) begin
          if (m_lines > 0 && low != H_BLK) m_bad_gap++;
          pos = 0;
          if (m_lines == act_line) begin
            pattern_sel = act_sel;
            en = act_en;
          end
        end
        if (m_lines < V_ACT && pos < 2*H_ACT) fbuf[m_lines][pos] = cmos_data;
        pos++;
      end else begin
        if (prev) begin
          if (pos != 2*H_ACT) m_bad_len++;
          m_lines++;
          low = 0;
        end
        low++;
        if (cmos_data !== 8'h00) m_idle_data++;
      end
      prev = cmos_href;
      step(); cyc++;
    end
    if (cyc >= LIMIT) m_timeout = 1;
    m_tail = low + 1;
    m_done_cnt = frame_cnt;
    step();
    m_after_done = frame_done;
    m_after_vs = cmos_vsync;
    m_after_busy = busy;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0; en = 1'b0; pattern_sel = 2'd0;
    #3;
    tests_run++;
    if ({cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy} !== 28'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got vs=%b href=%b data=%h done=%b cnt=%h busy=%b, want all zero",
               cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if ({cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy} !== 28'h0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold: %0d cycles left reset values with en=0, want 0", bad);
    end
  endtask

  task automatic test_colour_bars();
    pattern_sel = 2'd0;
    en = 1'b1;
    step();
    tests_run++;
    if (cmos_vsync !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_latency: vs=%b busy=%b, want 1 1", cmos_vsync, busy);
    end
    // The select moves to 2 during line 5; this frame must keep the bars.
    run_frame(5, 2'd2, 1'b1);
    tests_run++;
    if (m_timeout !== 0) begin
      tests_failed++; $display("[TB] FAIL bars_timeout: frame did not finish");
    end
    tests_run++;
    if (m_vs_len !== VS_L*LINE) begin
      tests_failed++; $display("[TB] FAIL vsync_len: got %0d want %0d", m_vs_len, VS_L*LINE);
    end
    tests_run++;
    if (m_back !== V_BK*LINE) begin
      tests_failed++; $display("[TB] FAIL back_porch: got %0d want %0d", m_back, V_BK*LINE);
    end
    tests_run++;
    if (m_lines !== V_ACT || m_bad_len !== 0 || m_bad_gap !== 0) begin
      tests_failed++;
      $display("[TB] FAIL href_shape: lines=%0d badlen=%0d badgap=%0d want %0d 0 0",
               m_lines, m_bad_len, m_bad_gap, V_ACT);
    end
    tests_run++;
    if (m_tail !== H_BLK + V_FR*LINE || m_idle_data !== 0) begin
      tests_failed++;
      $display("[TB] FAIL front_porch: tail=%0d idle_data=%0d want %0d 0",
               m_tail, m_idle_data, H_BLK + V_FR*LINE);
    end
    tests_run++;
    if ({fbuf[0][0], fbuf[0][1], fbuf[0][66], fbuf[0][67], fbuf[0][68], fbuf[0][69]} !== 48'hFFFF_FFFF_FFE0) begin
      tests_failed++;
      $display("[TB] FAIL bars_edge: got %h%h %h%h %h%h want FFFF FFFF FFE0",
               fbuf[0][0], fbuf[0][1], fbuf[0][66], fbuf[0][67], fbuf[0][68], fbuf[0][69]);
    end
    tests_run++;
    if ({fbuf[17][272], fbuf[17][273], fbuf[17][542], fbuf[17][543], fbuf[17][68]} !== 40'hF81F_0000_FF) begin
      tests_failed++;
      $display("[TB] FAIL bars_late: got %h%h %h%h %h want F81F 0000 FF",
               fbuf[17][272], fbuf[17][273], fbuf[17][542], fbuf[17][543], fbuf[17][68]);
    end
    tests_run++;
    if (m_done_cnt !== 16'd1 || m_after_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_count: cnt=%h after=%b want 0001 0", m_done_cnt, m_after_done);
    end
  endtask

  task automatic test_back_to_back();
    tests_run++;
    if (m_after_vs !== 1'b1 || m_after_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: vs=%b busy=%b want 1 1", m_after_vs, m_after_busy);
    end
    // Frame 2 uses frame_cnt = 1, so red 01 and blue 1E give 081E.
    run_frame(2, 2'd3, 1'b1);
    tests_run++;
    if (m_timeout !== 0 || {fbuf[0][0], fbuf[0][1], fbuf[9][300], fbuf[17][543]} !== 32'h081E_081E) begin
      tests_failed++;
      $display("[TB] FAIL count_colour: to=%0d got %h%h %h %h want 081E 08 1E", m_timeout,
               fbuf[0][0], fbuf[0][1], fbuf[9][300], fbuf[17][543]);
    end
    tests_run++;
    if (m_done_cnt !== 16'd2 || m_after_vs !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL frame2_done: cnt=%h vs=%b want 0002 1", m_done_cnt, m_after_vs);
    end
  endtask

  task automatic test_checker();
    run_frame(3, 2'd1, 1'b1);
    tests_run++;
    if ({fbuf[0][0], fbuf[0][1], fbuf[0][32], fbuf[0][33]} !== 32'h0000_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL checker_row0: got %h%h %h%h want 0000 FFFF",
               fbuf[0][0], fbuf[0][1], fbuf[0][32], fbuf[0][33]);
    end
    tests_run++;
    if ({fbuf[16][0], fbuf[16][1], fbuf[16][32], fbuf[16][33]} !== 32'hFFFF_0000) begin
      tests_failed++;
      $display("[TB] FAIL checker_row16: got %h%h %h%h want FFFF 0000",
               fbuf[16][0], fbuf[16][1], fbuf[16][32], fbuf[16][33]);
    end
    tests_run++;
    if (m_done_cnt !== 16'd3) begin
      tests_failed++; $display("[TB] FAIL frame3_done: cnt=%h want 0003", m_done_cnt);
    end
  endtask

  task automatic test_grey_ramp_stop();
    int stray = 0;
    run_frame(10, 2'd1, 1'b0);
    tests_run++;
    if ({fbuf[0][510], fbuf[0][511], fbuf[0][512], fbuf[0][513], fbuf[4][200], fbuf[4][201]} !== 48'hFFFF_0000_632C) begin
      tests_failed++;
      $display("[TB] FAIL grey_ramp: got %h%h %h%h %h%h want FFFF 0000 632C",
               fbuf[0][510], fbuf[0][511], fbuf[0][512], fbuf[0][513], fbuf[4][200], fbuf[4][201]);
    end
    tests_run++;
    if (m_lines !== V_ACT || m_done_cnt !== 16'd4 || m_timeout !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stop_full_frame: lines=%0d cnt=%h to=%0d want %0d 0004 0",
               m_lines, m_done_cnt, m_timeout, V_ACT);
    end
    tests_run++;
    if (m_after_busy !== 1'b0 || m_after_vs !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stop_busy: busy=%b vs=%b want 0 0", m_after_busy, m_after_vs);
    end
    for (int i = 0; i < 200; i++) begin
      step();
      if (cmos_vsync !== 1'b0 || busy !== 1'b0) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++; $display("[TB] FAIL stop_no_vsync: %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_reset_mid_href();
    int cyc = 0;
    en = 1'b1;
    while (cmos_href !== 1'b1 && cyc < LIMIT) begin
      step(); cyc++;
    end
    step(); step(); step();
    tests_run++;
    if (cmos_href !== 1'b1 || frame_cnt !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: href=%b cnt=%h want 1 0004", cmos_href, frame_cnt);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy} !== 28'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: vs=%b href=%b data=%h done=%b cnt=%h busy=%b want all zero",
               cmos_vsync, cmos_href, cmos_data, frame_done, frame_cnt, busy);
    end
    step(); step();
    rst_n = 1'b1;
    tests_run++;
    if (cmos_vsync !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL restart_early: vs=%b want 0", cmos_vsync);
    end
    step();
    tests_run++;
    if (cmos_vsync !== 1'b1 || busy !== 1'b1 || cmos_href !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_vsync: vs=%b busy=%b href=%b want 1 1 0", cmos_vsync, busy, cmos_href);
    end
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_back_to_back();
    test_checker();
    test_grey_ramp_stop();
    test_reset_mid_href();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
